uart_receiver: RTL
==================

# uart_receiver

UART receive end of the debug/configuration serial link: deserialises 8N1 frames (8E1 with parity built in) from an asynchronous `rx_i` line into bytes. Delivers each byte on a single-entry valid/ready output register towards the on-chip consumer, the PMU readout and command logic. It is the peer of the existing UART `transmitter`, uses the same `CLK_FREQ`/`BAUD_RATE` parameterisation and is loop-back-compatible with it.

## Interface
- `CLK_FREQ`, default 1_000_000_000: core clock frequency, Hz.
- `BAUD_RATE`, default 100_000_000: line bit rate, bit/s.
- `CLK_PER_BAUD`, default `CLK_FREQ / BAUD_RATE` (10): clocks per bit; must be ≥ 4; odd values are allowed and the half-bit is `CLK_PER_BAUD/2`, truncated.
- `clk_i`  in  1  core clock. All logic uses its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_o`  out  8  received byte; stable while `data_valid_o` is high.
- `data_valid_o`  out  1  byte available.
- `data_ready_i`  in  1  consumer accepts the byte; a transfer happens when valid and ready are both high.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun_o`  out  1  one-cycle pulse: byte completed while the output register was occupied; the new byte is dropped.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.

## Operation
- `rx_i` passes through a 2-flop synchroniser, reset to 1. The FSM sees only the synchronised value `rx_s`.
- FSM states and transitions:
  - IDLE: on `rx_s==0`, go to START and clear the bit counter.
  - START: wait `CLK_PER_BAUD/2` cycles, then sample. If `rx_s==0`, go to DATA. If `rx_s==1`, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every `CLK_PER_BAUD` cycles. Shift LSB first into the shift register. After the 8th bit go to PARITY (macro) or STOP.
  - PARITY: sample one bit. Even parity is required, so the XOR of the 8 data bits and the parity bit must be 0.
  - STOP: sample one bit.
    - If `rx_s==1` and parity is OK: commit the byte and go to IDLE.
    - If `rx_s==0`: pulse `frame_err_o`, discard the byte, go to WAIT_IDLE.
    - If `rx_s==1` with a parity error: pulse `parity_err_o`, discard the byte, go to IDLE.
  - WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Commit:
  - If `data_valid_o==0`, or `data_ready_i==1` in the same cycle: load `data_o` and set `data_valid_o`. A simultaneous accept and load keeps valid high and delivers the new byte.
  - Otherwise: pulse `overrun_o`, keep the old byte, drop the new one.
- `data_valid_o` clears on a transfer if no commit happens in the same cycle.
- Baud counter width: `$clog2(CLK_PER_BAUD)`. It reloads on every sample and wraps with no accumulated drift. Bit-period error is 0 cycles per bit for an ideal line.
- Reset:
  - Outputs: `data_o`=0, `data_valid_o`=0, all error pulses 0.
  - Internal state: FSM goes to IDLE, counters and shift register go to 0.
  - A reset mid-frame abandons the frame. Any remaining low bits of that frame may be taken as a start bit; the bench releases reset only with the line idle.

## Timing
- T0 is the first `clk_i` edge at which `rx_i` is sampled 0.
- The start bit is sampled at T0 + 2 + `CLK_PER_BAUD/2`.
- Data bit k (k=0..7) is sampled at that point + (k+1)·`CLK_PER_BAUD`.
- `data_valid_o` rises at T0 + 3 + `CLK_PER_BAUD/2` + 9·`CLK_PER_BAUD`. Add `CLK_PER_BAUD` with parity. With defaults this is 98 cycles (108 with parity).
- Error pulses occur in that same cycle, last exactly 1 cycle, and are mutually exclusive.
- Next start detection: IDLE is entered the cycle after the stop sample. A start bit following immediately (back-to-back frames) is caught, because the stop sample is at mid-bit.
- Minimum low pulse rejected as a glitch: shorter than `CLK_PER_BAUD/2` cycles.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start + 8 data + even parity + stop. The PARITY state and `parity_err_o` logic are present.
- Not defined: frame is 8N1. The PARITY state is absent and `parity_err_o` is constant 0.

## Test plan
- Idle, then send 0xA5 at default rate with `data_ready_i`=0 → `data_valid_o` rises 98 cycles after T0 with `data_o`=0xA5. Hold for 50 cycles with valid stable. Assert ready for 1 cycle → valid falls the next cycle.
- Drive `rx_i` low for 3 cycles, then high → no valid, no error pulses, FSM back in IDLE. A following 0x5A frame is received correctly.
- Send 0x3C with stop bit 0, then hold the line low for 30 cycles → one `frame_err_o` pulse, no valid. After the line returns high, a following 0x5A frame gives `data_o`=0x5A.
- Send 0x11 then 0x22 back-to-back with ready=0 → `data_o`=0x11, one `overrun_o` pulse at completion of 0x22. With ready held 1, 0x00 and 0xFF are both delivered and no overrun occurs.
- Assert `rst_i` for 2 cycles in the middle of the DATA state of 0x77, with the line forced idle → all outputs 0. A following 0xC3 frame is received exactly.
- With `UART_RX_PARITY_EN`: send 0x81 with parity 0 → valid at 108 cycles. Send 0x81 with parity 1 → one `parity_err_o` pulse and no valid.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a single-entry valid/ready output register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_receiver #(
  parameter int CLK_FREQ     = 1_000_000_000,
  parameter int BAUD_RATE    = 100_000_000,
  parameter int CLK_PER_BAUD = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CNT_W = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shift, shift_n;
  logic             commit;
  logic             frame_err_n;
  logic             parity_err_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
`endif

  // Synchroniser resets to the idle level so reset never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (rst_i) sync <= 2'b11;
    else       sync <= {sync[0], rx_i};
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) par_bad <= 1'b0;
    else       par_bad <= par_bad_n;
  end
`endif

  // Baud counter restarts at every sample point, so bit timing never drifts
  always_comb begin
    state_n      = state;
    baud_n       = baud_cnt;
    bit_n        = bit_cnt;
    shift_n      = shift;
    commit       = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n    = par_bad;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_n  = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n  = '0;
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n    = '0;
          par_bad_n = ^{shift, rx_s};
          state_n   = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n = '0;
          if (!rx_s) begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            parity_err_n = 1'b1;
            state_n      = IDLE;
`endif
          end else begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A commit may land in the same cycle the consumer takes the old byte
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o <= frame_err_n;
      overrun_o   <= 1'b0;
      if (commit) begin
        if (!data_valid_o || data_ready_i) begin
          data_o       <= shift;
          data_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) parity_err_o <= 1'b0;
    else       parity_err_o <= parity_err_n;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
